ahb_dmem_slave: RTL
===================

# ahb_dmem_slave

AHB-Lite data-memory slave that sits directly downstream of the load/store unit's data bus port. It stores 32-bit words together with a 7-bit SECDED checksum, returns both on reads (`s_hrdata_o`/`s_hrdcheck_o`), and checks the 6-bit interface parity that accompanies every address phase. Illegal or corrupted transfers get the standard two-cycle AHB ERROR response. The block is used as the data-side memory in core-level simulation and FPGA builds.

## Interface
- `MEM_WORDS`, default 1024: number of 32-bit words. The legal byte-address range is 0 to MEM_WORDS*4-1. Must be a power of two.
- `WAIT_STATES`, default 0: wait cycles inserted in every OKAY data phase. Range 0..3.
- `s_clk_i`, in, 1: clock.
- `s_reset_i`, in, 1: reset, asynchronous, active-high.
- `s_hsel_i`, in, 1: slave select.
- `s_haddr_i`, in, 32: address.
- `s_htrans_i`, in, 2: transfer type. Bit 1 set means NONSEQ/SEQ.
- `s_hwrite_i`, in, 1: write indicator.
- `s_hsize_i`, in, 3: 0 = byte, 1 = half, 2 = word.
- `s_hparity_i`, in, 6: address-phase parity.
- `s_hwdata_i`, in, 32: write data, valid in the data phase.
- `s_hwdcheck_i`, in, 7: checksum of the write data.
- `s_hrdata_o`, out, 32: read data.
- `s_hrdcheck_o`, out, 7: stored checksum of the read word.
- `s_hready_o`, out, 1: transfer done / slave ready.
- `s_hresp_o`, out, 1: ERROR response.
- `s_perr_o`, out, 1: one-cycle pulse when an address-phase parity mismatch is detected.

## Operation
- **Storage**
  - `mem[MEM_WORDS]` holds 32-bit data; `chk[MEM_WORDS]` holds 7-bit checksums.
  - Neither array is reset. Bench preload and backdoor corruption go through hierarchical access.
- **Address-phase sample**
  - Happens on a rising edge where `s_hready_o`=1, `s_hsel_i`=1 and `s_htrans_i[1]`=1.
  - Registers addr, write, size and the error verdict. Otherwise the block returns to IDLE.
- **Expected parity**
  - Bits [3:0] = XOR of `haddr` bytes [31:24], [23:16], [15:8], [7:0].
  - Bit [4] = (XOR of `hsize`) ^ `hwrite`.
  - Bit [5] = XOR of `htrans`.
- **Error verdict** (any one is enough):
  - parity mismatch;
  - `hsize` greater than 2;
  - misalignment (half with addr[0]=1, word with addr[1:0]≠0);
  - `haddr` ≥ MEM_WORDS*4.
- **Parity mismatch** additionally pulses `s_perr_o` in the cycle after the sample.
- **FSM states**
  - **IDLE**: `hready`=1, `hresp`=0.
  - **WAIT**: `hready`=0, counts WAIT_STATES cycles.
  - **DONE**: `hready`=1, `hresp`=0.
  - **ERR1**: `hready`=0, `hresp`=1.
  - **ERR2**: `hready`=1, `hresp`=1.
- **FSM transitions**
  - On an accepted transfer with an error: go to ERR1, then ERR2.
  - On an accepted transfer without an error: go to DONE if WAIT_STATES=0, otherwise WAIT (WAIT_STATES cycles), then DONE.
  - From DONE or ERR2: if a new address phase is sampled, go straight to its first state; otherwise go to IDLE.
- **Read**
  - In DONE: `s_hrdata_o` = `mem[addr[31:2]]`, `s_hrdcheck_o` = `chk[addr[31:2]]`.
  - The full word is returned regardless of size.
  - Outside DONE-read, both outputs are 0.
- **Write commit**
  - Happens at the rising edge ending DONE. Byte lanes are selected by size and addr:
    - byte: lane addr[1:0];
    - half: lanes {addr[1],0} and {addr[1],1};
    - word: all four lanes.
  - Word write: store `s_hwdcheck_i` unchanged. There is no recompute, so end-to-end errors propagate.
  - Sub-word write: store secded_encode(merged word), where the merged word is the old word with the selected lanes replaced.
- **ERROR transfers** never modify memory.
- **No stored-data correction**: the consumer decodes.

## Timing
- Reset values:
  - `s_hready_o`=1, `s_hresp_o`=0, `s_hrdata_o`=0, `s_hrdcheck_o`=0, `s_perr_o`=0, FSM=IDLE, wait counter=0.
- Latency, sample edge to completing edge:
  - OKAY: WAIT_STATES+1 cycles.
  - ERROR: 2 cycles.
- Back-to-back: a write to word W followed immediately by a read of W returns the new data. The commit edge precedes the read's DONE cycle.
- `hwdata`/`hwdcheck` are sampled only at the edge ending DONE of a write; wait cycles ignore them.
- Reset asserted mid-transfer:
  - Immediate return to IDLE.
  - A pending write is dropped.
  - A transfer in ERR1 is abandoned.
- An IDLE/BUSY `htrans`, or `hsel`=0 while `hready`=1: no state change beyond IDLE, and no `perr` check.
- Parity is checked only for accepted transfers.

## Test plan
- **Word write/read, WAIT_STATES=0**: write 0xDEADBEEF with check 0x5A to addr 0x10, then read 0x10. Expect `hrdata`=0xDEADBEEF, `hrdcheck`=0x5A, `hready` high every cycle, `hresp`=0.
- **Byte merge**: word 0x11223344 preloaded at 0x20; byte write 0xAB at 0x22. Readback gives 0x11AB3344 and `hrdcheck` = secded_encode(0x11AB3344).
- **Parity fault**: word read of 0x40 with `hparity[2]` flipped. Expect `s_perr_o` pulse, then `hready`=0/`hresp`=1, then `hready`=1/`hresp`=1; memory unchanged.
- **Illegal transfers**: half write at 0x31, then word read at MEM_WORDS*4. Each gets a two-cycle ERROR; `s_perr_o` stays 0.
- **Wait states, WAIT_STATES=2**: read 0x10. Expect `hready` low for 2 cycles, data valid in the third cycle.
- **Reset mid-write**: WAIT_STATES=3, write 0xCAFEF00D to 0x8; assert `s_reset_i` in the second wait cycle. Expect `hready`=1 immediately and old contents of 0x8 preserved.

Source files
------------

// File: rtl/ahb_dmem_slave.sv
// ----------------------------------------------------------------------------
// ahb_dmem_slave
//
// AHB-Lite data-memory slave for the load/store unit's data bus. It stores
// 32-bit words, each with a 7-bit SECDED checksum, and checks the 6-bit parity
// that comes with every address phase. Parity faults, oversize transfers,
// misaligned transfers and out-of-range addresses get the two-cycle AHB
// ERROR response and never change memory. A word write stores the checksum
// supplied by the master as it is, so an end-to-end error stays visible to
// the consumer. A sub-word write stores a checksum recomputed over the
// merged word.
//
// Parameters
//   MEM_WORDS    number of 32-bit words (power of two)
//   WAIT_STATES  wait cycles in every OKAY data phase (0..3)
//
// Ports
//   s_clk_i, s_reset_i         clock, asynchronous active-high reset
//   s_hsel_i .. s_hparity_i    address phase: select, address, transfer type,
//                              write flag, size, address-phase parity
//   s_hwdata_i, s_hwdcheck_i   write data and its checksum (data phase)
//   s_hrdata_o, s_hrdcheck_o   read word and its stored checksum
//   s_hready_o, s_hresp_o      AHB ready / ERROR response
//   s_perr_o                   one-cycle pulse on an address parity mismatch
// ----------------------------------------------------------------------------
module ahb_dmem_slave #(
    parameter int MEM_WORDS   = 1024,
    parameter int WAIT_STATES = 0
) (
    input  logic        s_clk_i,
    input  logic        s_reset_i,
    input  logic        s_hsel_i,
    input  logic [31:0] s_haddr_i,
    input  logic [1:0]  s_htrans_i,
    input  logic        s_hwrite_i,
    input  logic [2:0]  s_hsize_i,
    input  logic [5:0]  s_hparity_i,
    input  logic [31:0] s_hwdata_i,
    input  logic [6:0]  s_hwdcheck_i,
    output logic [31:0] s_hrdata_o,
    output logic [6:0]  s_hrdcheck_o,
    output logic        s_hready_o,
    output logic        s_hresp_o,
    output logic        s_perr_o
);

    localparam int          AW        = $clog2(MEM_WORDS);
    localparam logic [32:0] MEM_BYTES = 33'(MEM_WORDS) * 33'd4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_DONE,
        S_ERR1,
        S_ERR2
    } state_t;

    // Hamming(38,32) check bits over codeword positions 1..38. The check bits
    // sit at the power-of-two positions and the data bits fill the rest in
    // ascending order. Bit 6 is the overall parity of data and check bits.
    function automatic logic [6:0] secded_encode(input logic [31:0] data);
        logic [6:0] c;
        int         k;
        c = '0;
        k = 0;
        for (int pos = 1; pos <= 38; pos++) begin
            if ((pos & (pos - 1)) != 0) begin
                for (int i = 0; i < 6; i++) begin
                    if (pos[i]) c[i] = c[i] ^ data[k];
                end
                k++;
            end
        end
        c[6] = ^{data, c[5:0]};
        return c;
    endfunction

    logic [31:0] mem [MEM_WORDS];
    logic [6:0]  chk [MEM_WORDS];

    state_t      state, state_nxt;
    logic [1:0]  wait_cnt, wait_cnt_nxt;
    logic [AW+1:0] addr_q;
    logic        write_q;
    logic [2:0]  size_q;

    // ---------------------------------------------------------------- address phase
    logic       accept;
    logic [5:0] exp_parity;
    logic       par_err;
    logic       xfer_err;

    assign accept     = s_hready_o && s_hsel_i && s_htrans_i[1];
    assign exp_parity = {^s_htrans_i,
                         (^s_hsize_i) ^ s_hwrite_i,
                         ^s_haddr_i[31:24], ^s_haddr_i[23:16],
                         ^s_haddr_i[15:8],  ^s_haddr_i[7:0]};
    assign par_err    = (s_hparity_i != exp_parity);
    assign xfer_err   = par_err
                     || (s_hsize_i > 3'd2)
                     || ((s_hsize_i == 3'd1) && s_haddr_i[0])
                     || ((s_hsize_i == 3'd2) && (s_haddr_i[1:0] != 2'b00))
                     || ({1'b0, s_haddr_i} >= MEM_BYTES);

    // ---------------------------------------------------------------- state registers
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge s_clk_i or posedge s_reset_i) begin
        if (s_reset_i) begin
            state    <= S_IDLE;
            wait_cnt <= '0;
            addr_q   <= '0;
            write_q  <= 1'b0;
            size_q   <= '0;
            s_perr_o <= 1'b0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
            s_perr_o <= accept && par_err;
            if (accept) begin
                addr_q  <= s_haddr_i[AW+1:0];
                write_q <= s_hwrite_i;
                size_q  <= s_hsize_i;
            end
        end
    end

    // ---------------------------------------------------------------- next state
    // NOTE: every signal driven here gets a default first, so no path through
    // the case can leave it unassigned and infer a latch.
    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        case (state)
            S_WAIT: begin
                if (wait_cnt == 2'(WAIT_STATES - 1)) begin
                    state_nxt    = S_DONE;
                    wait_cnt_nxt = '0;
                end else begin
                    wait_cnt_nxt = wait_cnt + 2'd1;
                end
            end
            S_ERR1: state_nxt = S_ERR2;
            default: begin
                // IDLE, DONE and ERR2 are the ready states: a new address
                // phase goes straight to its first data-phase state.
                state_nxt = S_IDLE;
                if (accept) begin
                    wait_cnt_nxt = '0;
                    if (xfer_err)              state_nxt = S_ERR1;
                    else if (WAIT_STATES == 0) state_nxt = S_DONE;
                    else                       state_nxt = S_WAIT;
                end
            end
        endcase
    end

    always_comb begin
        s_hready_o = 1'b1;
        s_hresp_o  = 1'b0;
        case (state)
            S_WAIT: s_hready_o = 1'b0;
            S_ERR1: begin
                s_hready_o = 1'b0;
                s_hresp_o  = 1'b1;
            end
            S_ERR2: s_hresp_o = 1'b1;
            default: ;
        endcase
    end

    // ---------------------------------------------------------------- data path
    logic [AW-1:0] word_idx;
    logic [31:0]   rd_word;
    logic [3:0]    lane_en;
    logic [31:0]   merged;
    logic          commit;

    assign word_idx = addr_q[AW+1:2];
    assign rd_word  = mem[word_idx];
    assign commit   = (state == S_DONE) && write_q && !s_reset_i;

    assign s_hrdata_o   = ((state == S_DONE) && !write_q) ? rd_word       : '0;
    assign s_hrdcheck_o = ((state == S_DONE) && !write_q) ? chk[word_idx] : '0;

    always_comb begin
        lane_en = 4'b0000;
        case (size_q)
            3'd0:    lane_en[addr_q[1:0]] = 1'b1;
            3'd1:    lane_en = addr_q[1] ? 4'b1100 : 4'b0011;
            default: lane_en = 4'b1111;
        endcase
        for (int b = 0; b < 4; b++) begin
            merged[8*b +: 8] = lane_en[b] ? s_hwdata_i[8*b +: 8] : rd_word[8*b +: 8];
        end
    end

    // NOTE: the storage arrays are deliberately left out of reset; they map
    // onto RAM, and their contents are defined by the writes alone.
    always_ff @(posedge s_clk_i) begin
        if (commit) begin
            mem[word_idx] <= merged;
            chk[word_idx] <= (size_q == 3'd2) ? s_hwdcheck_i : secded_encode(merged);
        end
    end

endmodule
